// File: rtl/load_store_unit.sv
// Load/store stage: one handshaked data-memory access per load/store, with byte-lane steering,
// sign/zero extension, alignment/legality checks and a bus timeout; stalls the core while busy.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_is_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_err_misaligned,
  output logic        o_err_illegal,
  output logic        o_err_bus,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_byte_lane;
  logic [31:0] w_half_lane;
  logic [31:0] w_ld;

  assign w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                     (i_req_funct3 == 3'b111) || (i_req_is_store && i_req_funct3[2]);
  assign w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                        ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  // Last REQ cycle allowed without ack; an ack in that same cycle still completes normally.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign o_stall = ((r_state == S_IDLE) && i_req_valid) || (r_state == S_REQ);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = i_req_wdata;
    case (i_req_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {i_req_addr[1], 1'b0};
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!i_req_is_store) w_wstrb = 4'b0000;
  end

  assign w_byte_lane = i_mem_rdata >> {r_off, 3'b000};
  assign w_half_lane = i_mem_rdata >> {r_off[1], 4'b0000};

  always_comb begin
    w_ld = i_mem_rdata;
    case (r_f3)
      3'b000:  w_ld = {{24{w_byte_lane[7]}}, w_byte_lane[7:0]};
      3'b100:  w_ld = {24'd0, w_byte_lane[7:0]};
      3'b001:  w_ld = {{16{w_half_lane[15]}}, w_half_lane[15:0]};
      3'b101:  w_ld = {16'd0, w_half_lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_off            <= 2'b00;
      r_f3             <= 3'b000;
      o_done           <= 1'b0;
      o_load_data      <= 32'd0;
      o_err_misaligned <= 1'b0;
      o_err_illegal    <= 1'b0;
      o_err_bus        <= 1'b0;
      o_mem_req        <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_addr       <= 32'd0;
      o_mem_wstrb      <= 4'd0;
      o_mem_wdata      <= 32'd0;
    end else begin
      o_done           <= 1'b0;
      o_err_misaligned <= 1'b0;
      o_err_illegal    <= 1'b0;
      o_err_bus        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid) begin
            if (w_illegal) begin
              r_state       <= S_ERR;
              o_done        <= 1'b1;
              o_err_illegal <= 1'b1;
            end else if (w_misaligned) begin
              r_state          <= S_ERR;
              o_done           <= 1'b1;
              o_err_misaligned <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_off       <= i_req_addr[1:0];
              r_f3        <= i_req_funct3;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_req_is_store;
              o_mem_addr  <= {i_req_addr[31:2], 2'b00};
              o_mem_wstrb <= w_wstrb;
              o_mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            r_state   <= S_DONE;
            o_mem_req <= 1'b0;
            o_done    <= 1'b1;
            if (!o_mem_we) o_load_data <= w_ld;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            o_mem_req <= 1'b0;
            o_done    <= 1'b1;
            o_err_bus <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
